id_exe_stage_reg: RTL and testbench

Parametrised decode-to-execute pipeline stage register with a valid/ready handshake, flush, optional two-entry skid buffer and a saturating stall counter. It sits between ID and EXE. It latches operands, with immediate/register operand selection done at load time, plus ALU control and write-back control. Backpressure from EXE stalls ID without dropping or duplicating instructions.

---
 rtl/id_exe_stage_reg.sv | 165 ++++++++++++++++
 tb/tb_id_exe_stage_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage_reg.sv
// ID-to-EXE pipeline register with valid/ready handshake, flush and a saturating stall counter.
// Define ID_EXE_SKID_EN to add a second (skid) entry and a registered in_ready.
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_rt,
    input  logic              in_opr1_sel,
    input  logic              in_opr2_sel,
    input  logic [3:0]        in_alu_ctrl,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic [1:0]        in_wsel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_opr1,
    output logic [DATA_W-1:0] out_opr2,
    output logic [3:0]        out_alu_ctrl,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_waddr,
    output logic [1:0]        out_wsel,
    output logic [DATA_W-1:0] out_rt,
    output logic [DATA_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] opr1;
        logic [DATA_W-1:0] opr2;
        logic [DATA_W-1:0] rt;
        logic [DATA_W-1:0] pc;
        logic [31:0]       instr;
        logic [3:0]        alu_ctrl;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [1:0]        wsel;
    } entry_t;

    entry_t            in_entry;
    entry_t            main_q, main_d;
    logic              main_valid_q, main_valid_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              accept, transfer;

    // Operand selection happens here so EXE sees ready-to-use operands.
    always_comb begin
        in_entry          = '0;
        in_entry.opr1     = in_opr1_sel ? in_imm : in_rs;
        in_entry.opr2     = in_opr2_sel ? in_imm : in_rt;
        in_entry.rt       = in_rt;
        in_entry.pc       = in_pc;
        in_entry.instr    = in_instr;
        in_entry.alu_ctrl = in_alu_ctrl;
        in_entry.we       = in_we;
        in_entry.waddr    = in_waddr;
        in_entry.wsel     = in_wsel;
    end

    assign accept   = in_valid & in_ready;
    assign transfer = main_valid_q & out_ready;

`ifdef ID_EXE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    // in_ready comes straight from a flop, so out_ready never reaches ID combinationally.
    assign in_ready = !skid_valid_q;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end
        end else if (transfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (!skid_valid_q && accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !main_valid_q | out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
        end else if (transfer) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    always_comb begin
        stall_d = stall_q;
        if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            stall_q      <= stall_d;
        end
    end

    assign out_valid    = main_valid_q;
    assign out_opr1     = main_q.opr1;
    assign out_opr2     = main_q.opr2;
    assign out_alu_ctrl = main_q.alu_ctrl;
    assign out_we       = main_q.we & main_valid_q;
    assign out_waddr    = main_q.waddr;
    assign out_wsel     = main_q.wsel;
    assign out_rt       = main_q.rt;
    assign out_pc       = main_q.pc;
    assign out_instr    = main_q.instr;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg: vector table for streaming/operand select,
// hand sequences for backpressure, flush and counter saturation (second instance, CNT_W=4).
module tb_id_exe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_instr, in_imm, in_rs, in_rt;
    logic        in_opr1_sel, in_opr2_sel, in_we;
    logic [3:0]  in_alu_ctrl;
    logic [4:0]  in_waddr;
    logic [1:0]  in_wsel;

    logic        in_ready, out_valid, out_we;
    logic [31:0] out_opr1, out_opr2, out_rt, out_pc, out_instr;
    logic [3:0]  out_alu_ctrl;
    logic [4:0]  out_waddr;
    logic [1:0]  out_wsel;
    logic [15:0] stall_cnt;

    logic        out_ready2 = 1'b0;
    logic        in_ready2, out_valid2, out_we2;
    logic [31:0] out_opr1_2, out_opr2_2, out_rt2, out_pc2, out_instr2;
    logic [3:0]  out_alu_ctrl2;
    logic [4:0]  out_waddr2;
    logic [1:0]  out_wsel2;
    logic [3:0]  stall_cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt),
        .in_opr1_sel(in_opr1_sel), .in_opr2_sel(in_opr2_sel), .in_alu_ctrl(in_alu_ctrl),
        .in_we(in_we), .in_waddr(in_waddr), .in_wsel(in_wsel),
        .out_valid(out_valid), .out_ready(out_ready), .out_opr1(out_opr1), .out_opr2(out_opr2),
        .out_alu_ctrl(out_alu_ctrl), .out_we(out_we), .out_waddr(out_waddr), .out_wsel(out_wsel),
        .out_rt(out_rt), .out_pc(out_pc), .out_instr(out_instr), .stall_cnt(stall_cnt)
    );

    id_exe_stage_reg #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_pc(in_pc), .in_instr(in_instr), .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt),
        .in_opr1_sel(in_opr1_sel), .in_opr2_sel(in_opr2_sel), .in_alu_ctrl(in_alu_ctrl),
        .in_we(in_we), .in_waddr(in_waddr), .in_wsel(in_wsel),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_opr1(out_opr1_2), .out_opr2(out_opr2_2),
        .out_alu_ctrl(out_alu_ctrl2), .out_we(out_we2), .out_waddr(out_waddr2), .out_wsel(out_wsel2),
        .out_rt(out_rt2), .out_pc(out_pc2), .out_instr(out_instr2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic        valid, ready, s1, s2, we;
        logic [31:0] pc, imm, rs, rt;
        logic [3:0]  alu;
        logic [4:0]  waddr;
        logic [1:0]  wsel;
        logic        e_valid, e_we, e_ready;
        logic [31:0] e_pc, e_opr1, e_opr2, e_rt;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of a simple transaction: operands derived from pc, no immediates.
    task automatic drive(input logic v, input logic r, input logic [31:0] pc, input logic f);
        in_valid    = v;
        out_ready   = r;
        flush       = f;
        in_pc       = pc;
        in_instr    = 32'h1300_0000 | pc;
        in_rs       = 32'hA000_0000 | pc;
        in_rt       = 32'hB000_0000 | pc;
        in_imm      = 32'h0;
        in_opr1_sel = 1'b0;
        in_opr2_sel = 1'b0;
        in_we       = 1'b1;
        in_alu_ctrl = 4'h3;
        in_waddr    = 5'd7;
        in_wsel     = 2'd1;
        step();
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                              input logic rdy, input logic [15:0] st);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        if (v) chk({tag, ".out_pc"}, 64'(out_pc), 64'(pc));
        if (v) chk({tag, ".out_opr1"}, 64'(out_opr1), 64'(32'hA000_0000 | pc));
        chk({tag, ".out_we"}, 64'(out_we), 64'(v));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(st));
        $display("%s: valid=%0d pc=0x%0h in_ready=%0d stall=%0d", tag, out_valid, out_pc, in_ready, stall_cnt);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vt[i] = '{valid:1'b1, ready:1'b1, s1:1'b0, s2:1'b0, we:1'b1,
                      pc:32'(4*i), imm:32'h300 + 32'(i), rs:32'h100 + 32'(i), rt:32'h200 + 32'(i),
                      alu:4'(i), waddr:5'(i), wsel:2'(i),
                      e_valid:1'b1, e_we:1'b1, e_ready:1'b1,
                      e_pc:32'(4*i), e_opr1:32'h100 + 32'(i), e_opr2:32'h200 + 32'(i),
                      e_rt:32'h200 + 32'(i), e_stall:16'd0};
        end
        vt[8]  = '{valid:1'b1, ready:1'b1, s1:1'b1, s2:1'b0, we:1'b0,
                   pc:32'h20, imm:32'h10, rs:32'hDEADBEEF, rt:32'h5, alu:4'hA, waddr:5'd9, wsel:2'd2,
                   e_valid:1'b1, e_we:1'b0, e_ready:1'b1,
                   e_pc:32'h20, e_opr1:32'h10, e_opr2:32'h5, e_rt:32'h5, e_stall:16'd0};
        vt[9]  = '{valid:1'b1, ready:1'b1, s1:1'b0, s2:1'b1, we:1'b1,
                   pc:32'h24, imm:32'hABCD, rs:32'h11, rt:32'h22, alu:4'hF, waddr:5'd31, wsel:2'd3,
                   e_valid:1'b1, e_we:1'b1, e_ready:1'b1,
                   e_pc:32'h24, e_opr1:32'h11, e_opr2:32'hABCD, e_rt:32'h22, e_stall:16'd0};
        // Idle cycle: entry drains, data stays stale, out_we forced low.
        vt[10] = '{valid:1'b0, ready:1'b1, s1:1'b0, s2:1'b0, we:1'b1,
                   pc:32'h28, imm:32'h0, rs:32'h0, rt:32'h0, alu:4'h0, waddr:5'd0, wsel:2'd0,
                   e_valid:1'b0, e_we:1'b0, e_ready:1'b1,
                   e_pc:32'h24, e_opr1:32'h11, e_opr2:32'hABCD, e_rt:32'h22, e_stall:16'd0};

        // Reset held two cycles while ID offers an entry.
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h40, 1'b0);
        drive(1'b1, 1'b0, 32'h44, 1'b0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_we", 64'(out_we), 64'd0);
        chk("rst.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst.out_opr1", 64'(out_opr1), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.sat_stall", 64'(stall_cnt2), 64'd0);
        $display("reset: valid=%0d we=%0d stall=%0d opr1=0x%0h in_ready=%0d", out_valid, out_we, stall_cnt, out_opr1, in_ready);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            in_valid    = vt[i].valid;
            out_ready   = vt[i].ready;
            flush       = 1'b0;
            in_pc       = vt[i].pc;
            in_instr    = 32'h1300_0000 | vt[i].pc;
            in_imm      = vt[i].imm;
            in_rs       = vt[i].rs;
            in_rt       = vt[i].rt;
            in_opr1_sel = vt[i].s1;
            in_opr2_sel = vt[i].s2;
            in_we       = vt[i].we;
            in_alu_ctrl = vt[i].alu;
            in_waddr    = vt[i].waddr;
            in_wsel     = vt[i].wsel;
            chk($sformatf("vec%0d.pre_in_ready", i), 64'(in_ready), 64'd1);
            step();
            chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vt[i].e_valid));
            chk($sformatf("vec%0d.out_we", i), 64'(out_we), 64'(vt[i].e_we));
            chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(vt[i].e_ready));
            chk($sformatf("vec%0d.out_pc", i), 64'(out_pc), 64'(vt[i].e_pc));
            chk($sformatf("vec%0d.out_instr", i), 64'(out_instr), 64'(32'h1300_0000 | vt[i].e_pc));
            chk($sformatf("vec%0d.out_opr1", i), 64'(out_opr1), 64'(vt[i].e_opr1));
            chk($sformatf("vec%0d.out_opr2", i), 64'(out_opr2), 64'(vt[i].e_opr2));
            chk($sformatf("vec%0d.out_rt", i), 64'(out_rt), 64'(vt[i].e_rt));
            chk($sformatf("vec%0d.stall_cnt", i), 64'(stall_cnt), 64'(vt[i].e_stall));
            if (vt[i].valid) begin
                chk($sformatf("vec%0d.out_alu_ctrl", i), 64'(out_alu_ctrl), 64'(vt[i].alu));
                chk($sformatf("vec%0d.out_waddr", i), 64'(out_waddr), 64'(vt[i].waddr));
                chk($sformatf("vec%0d.out_wsel", i), 64'(out_wsel), 64'(vt[i].wsel));
            end
            $display("vec%0d: valid=%0d pc=0x%0h opr1=0x%0h opr2=0x%0h rt=0x%0h we=%0d",
                     i, out_valid, out_pc, out_opr1, out_opr2, out_rt, out_we);
        end

        // Backpressure: A stalls two cycles, then B and C follow with no gap.
`ifdef ID_EXE_SKID_EN
        drive(1'b1, 1'b0, 32'h100, 1'b0); expect_out("bp1", 1'b1, 32'h100, 1'b1, 16'd0);
        drive(1'b1, 1'b0, 32'h104, 1'b0); expect_out("bp2", 1'b1, 32'h100, 1'b0, 16'd1);
        drive(1'b1, 1'b0, 32'h108, 1'b0); expect_out("bp3", 1'b1, 32'h100, 1'b0, 16'd2);
        drive(1'b1, 1'b1, 32'h108, 1'b0); expect_out("bp4", 1'b1, 32'h104, 1'b1, 16'd2);
        drive(1'b1, 1'b1, 32'h108, 1'b0); expect_out("bp5", 1'b1, 32'h108, 1'b1, 16'd2);
        drive(1'b0, 1'b1, 32'h10C, 1'b0); expect_out("bp6", 1'b0, 32'h0,   1'b1, 16'd2);
        // Flush with both entries full and D offered.
        drive(1'b1, 1'b0, 32'h200, 1'b0); expect_out("fl1", 1'b1, 32'h200, 1'b1, 16'd2);
        drive(1'b1, 1'b0, 32'h204, 1'b0); expect_out("fl2", 1'b1, 32'h200, 1'b0, 16'd3);
        drive(1'b1, 1'b0, 32'hD00, 1'b1); expect_out("fl3", 1'b0, 32'h0,   1'b1, 16'd4);
        drive(1'b0, 1'b1, 32'h0,   1'b0); expect_out("fl4", 1'b0, 32'h0,   1'b1, 16'd4);
        drive(1'b0, 1'b1, 32'h0,   1'b0); expect_out("fl5", 1'b0, 32'h0,   1'b1, 16'd4);
`else
        drive(1'b1, 1'b0, 32'h100, 1'b0); expect_out("bp1", 1'b1, 32'h100, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 32'h104, 1'b0); expect_out("bp2", 1'b1, 32'h100, 1'b0, 16'd1);
        drive(1'b1, 1'b0, 32'h104, 1'b0); expect_out("bp3", 1'b1, 32'h100, 1'b0, 16'd2);
        drive(1'b1, 1'b1, 32'h104, 1'b0); expect_out("bp4", 1'b1, 32'h104, 1'b1, 16'd2);
        drive(1'b1, 1'b1, 32'h108, 1'b0); expect_out("bp5", 1'b1, 32'h108, 1'b1, 16'd2);
        drive(1'b0, 1'b1, 32'h10C, 1'b0); expect_out("bp6", 1'b0, 32'h0,   1'b1, 16'd2);
        // Flush with the entry full and D offered.
        drive(1'b1, 1'b0, 32'h200, 1'b0); expect_out("fl1", 1'b1, 32'h200, 1'b0, 16'd2);
        drive(1'b1, 1'b0, 32'hD00, 1'b1); expect_out("fl3", 1'b0, 32'h0,   1'b1, 16'd3);
        drive(1'b0, 1'b1, 32'h0,   1'b0); expect_out("fl4", 1'b0, 32'h0,   1'b1, 16'd3);
        drive(1'b0, 1'b1, 32'h0,   1'b0); expect_out("fl5", 1'b0, 32'h0,   1'b1, 16'd3);
`endif

        // Saturation on the 4-bit counter instance, whose out_ready is held low.
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        reset = 1'b0;
        chk("sat.reset", 64'(stall_cnt2), 64'd0);
        drive(1'b1, 1'b1, 32'h300, 1'b0);
        chk("sat.load_valid", 64'(out_valid2), 64'd1);
        chk("sat.load_cnt", 64'(stall_cnt2), 64'd0);
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b0);
            chk($sformatf("sat.cyc%0d", k), 64'(stall_cnt2), 64'((k > 15) ? 15 : k));
            $display("sat cyc%0d: stall_cnt=%0d valid=%0d", k, stall_cnt2, out_valid2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
